// File: rtl/sipo_frame_rx_if.sv
// Bundle of the serial-line, handshake and status signals of the frame
// receiver. The master side drives the line and acknowledges frames; the
// slave side is the receiver itself.
interface sipo_frame_rx_if #(
  parameter int WIDTH = 10
);
  logic             rx_en;
  logic             serial_in;
  logic             data_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  modport master (
    output rx_en,
    output serial_in,
    output data_ack,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );

  modport slave (
    input  rx_en,
    input  serial_in,
    input  data_ack,
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output busy
  );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver for the 10-bit LSB-first idle-high
// link. Detects a start bit, samples WIDTH bits (start and stop included),
// and holds the frame on a valid/ack handshake with framing-error and
// sticky overrun reporting.
module sipo_frame_rx #(
  parameter int WIDTH      = 10,
  parameter int BIT_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  sipo_frame_rx_if.slave  bus
);

  localparam int CNT_W  = 5;
  localparam int BAUD_W = 8;

  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(WIDTH - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF   = BAUD_W'(BIT_CYCLES / 2);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  // Holds the bits received so far; the stop bit never needs storing
  // because it is taken straight from the line on the completing edge.
  logic [WIDTH-2:0]    shift_q, shift_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;

  logic                complete;
  logic                ackHit;
  logic [WIDTH-1:0]    frameBits;

  // The full frame as it stands on the edge that samples the stop bit.
  assign frameBits = {bus.serial_in, shift_q};

  // Receive sequencer: start detection, mid-start confirmation for slow
  // links, and one sample per bit period shifted in from the top so that
  // bit i ends up in position i.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rx_en && !bus.serial_in) begin
          if (BIT_CYCLES == 1) begin
            shift_d = {bus.serial_in, shift_q[WIDTH-2:1]};
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end else begin
            baud_d  = BAUD_HALF;
            state_d = START;
          end
        end
      end
      START: begin
        if (baud_q == '0) begin
          if (bus.serial_in) begin
            state_d = IDLE;
          end else begin
            shift_d = {bus.serial_in, shift_q[WIDTH-2:1]};
            cnt_d   = CNT_W'(1);
            baud_d  = BAUD_RELOAD;
            state_d = SHIFT;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      SHIFT: begin
        if ((BIT_CYCLES == 1) || (baud_q == '0)) begin
          shift_d = {bus.serial_in, shift_q[WIDTH-2:1]};
          baud_d  = BAUD_RELOAD;
          if (cnt_q == LAST_BIT) begin
            complete = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output holding register and handshake: a completed frame replaces the
  // held one only if the slot is free or being acknowledged on the same
  // edge; otherwise the new frame is lost and overrun latches.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    ackHit  = valid_q && bus.data_ack;
    if (ackHit) begin
      ovr_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || bus.data_ack) begin
        data_d  = frameBits;
        ferr_d  = ~bus.serial_in;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ackHit) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  // State and data registers; reset aborts any frame in flight and
  // drops whatever was being held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      baud_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: table-driven frames on a 1-clock-per-bit
// receiver, hand sequences for back-to-back, overrun, reset, enable and a
// 4-clock-per-bit receiver, then random frames against a frame-level model.
module tb_sipo_frame_rx;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, en1, ser1, ack1;
  logic rst4, en4, ser4, ack4;

  sipo_frame_rx_if #(.WIDTH(W)) bus1 ();
  sipo_frame_rx_if #(.WIDTH(W)) bus4 ();

  assign bus1.rx_en     = en1;
  assign bus1.serial_in = ser1;
  assign bus1.data_ack  = ack1;
  assign bus4.rx_en     = en4;
  assign bus4.serial_in = ser4;
  assign bus4.data_ack  = ack4;

  sipo_frame_rx #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  sipo_frame_rx #(.WIDTH(W), .BIT_CYCLES(4)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (bus4)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] frame;
    logic         ackAtEnd;
    logic [W-1:0] expData;
    logic         expValid;
    logic         expErr;
    logic         expOvr;
    logic         ackAfter;
  } vec_t;

  vec_t vecs [6];

  // Frame-level reference model of the held output.
  logic [W-1:0] mData;
  logic         mValid, mErr, mOvr;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive one frame on the 1-clock-per-bit line, ack only on the stop bit.
  task automatic applyStimulus(input logic [W-1:0] f, input logic ackLast);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      ser1 = f[i];
      ack1 = (i == W - 1) ? ackLast : 1'b0;
    end
  endtask

  // Drive one frame on the 4-clocks-per-bit line.
  task automatic applyStimulus4(input logic [W-1:0] f);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      ser4 = f[i];
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic idle1();
    @(negedge clk);
    ser1 = 1'b1;
    ack1 = 1'b0;
  endtask

  task automatic ackPulse1();
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
  endtask

  task automatic checkDut1(input string tag, input logic [W-1:0] d,
                           input logic v, input logic e, input logic o);
    checkOutput({tag, " data"},    16'(bus1.data_out),   16'(d));
    checkOutput({tag, " valid"},   16'(bus1.data_valid), 16'(v));
    checkOutput({tag, " err"},     16'(bus1.frame_err),  16'(e));
    checkOutput({tag, " overrun"}, 16'(bus1.overrun),    16'(o));
  endtask

  task automatic modelStep(input logic comp, input logic [W-1:0] fr,
                           input logic ack);
    if (comp) begin
      if (!mValid || ack) begin
        if (mValid && ack) mOvr = 1'b0;
        mData  = fr;
        mErr   = ~fr[W-1];
        mValid = 1'b1;
      end else begin
        mOvr = 1'b1;
      end
    end else if (mValid && ack) begin
      mValid = 1'b0;
      mErr   = 1'b0;
      mOvr   = 1'b0;
    end
  endtask

  // Random frames with random gaps, stop bits and acks; the bench knows
  // where each frame ends, so the model only reacts to frame completions.
  task automatic runRandom();
    logic         serQ [$];
    logic         compQ [$];
    logic [W-1:0] frameQ [$];
    logic [W-1:0] fr;
    logic         a;
    for (int f = 0; f < 40; f++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        serQ.push_back(1'b1);
        compQ.push_back(1'b0);
        frameQ.push_back('0);
      end
      fr        = W'($urandom);
      fr[0]     = 1'b0;
      fr[W-1]   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < W; i++) begin
        serQ.push_back(fr[i]);
        compQ.push_back(i == W - 1);
        frameQ.push_back(fr);
      end
    end
    mData = '0; mValid = 1'b0; mErr = 1'b0; mOvr = 1'b0;
    for (int c = 0; c < serQ.size(); c++) begin
      @(negedge clk);
      checkDut1($sformatf("rand c=%0d", c), mData, mValid, mErr, mOvr);
      ser1 = serQ[c];
      a    = 1'($urandom_range(0, 1));
      ack1 = a;
      modelStep(compQ[c], frameQ[c], a);
    end
    idle1();
    checkDut1("rand end", mData, mValid, mErr, mOvr);
  endtask

  // Main sequence.
  initial begin
    vecs[0] = '{10'h34A, 1'b0, 10'h34A, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{10'h14A, 1'b0, 10'h14A, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{10'h3FE, 1'b1, 10'h3FE, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{10'h34A, 1'b0, 10'h3FE, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{10'h2AA, 1'b0, 10'h2AA, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{10'h0AA, 1'b1, 10'h0AA, 1'b1, 1'b1, 1'b0, 1'b1};

    rst1 = 1'b1; en1 = 1'b1; ser1 = 1'b1; ack1 = 1'b0;
    rst4 = 1'b1; en4 = 1'b1; ser4 = 1'b1; ack4 = 1'b0;
    repeat (2) @(negedge clk);
    checkDut1("reset", '0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset busy1", 16'(bus1.busy), 16'(0));
    checkOutput("reset busy4", 16'(bus4.busy), 16'(0));
    checkOutput("reset valid4", 16'(bus4.data_valid), 16'(0));
    rst1 = 1'b0;
    rst4 = 1'b0;

    // Table-driven frames, state carried from one record to the next.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].frame, vecs[i].ackAtEnd);
      idle1();
      checkDut1($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expValid,
                vecs[i].expErr, vecs[i].expOvr);
      if (vecs[i].ackAfter) begin
        ackPulse1();
        checkDut1($sformatf("vec%0d ack", i), vecs[i].expData, 1'b0, 1'b0, 1'b0);
      end
    end

    // Back-to-back frames with ack on the second completion.
    applyStimulus(10'h34A, 1'b0);
    applyStimulus(10'h3FE, 1'b1);
    idle1();
    checkDut1("b2b ack", 10'h3FE, 1'b1, 1'b0, 1'b0);
    ackPulse1();
    checkOutput("b2b ack clear", 16'(bus1.data_valid), 16'(0));

    // Back-to-back frames without ack: second one is dropped.
    applyStimulus(10'h34A, 1'b0);
    applyStimulus(10'h3FE, 1'b0);
    idle1();
    checkDut1("b2b overrun", 10'h34A, 1'b1, 1'b0, 1'b1);
    ackPulse1();
    checkDut1("b2b overrun ack", 10'h34A, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame while a frame is being held.
    applyStimulus(10'h2AA, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ser1 = vecs[0].frame[i];
    end
    @(negedge clk);
    rst1 = 1'b1;
    ser1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    checkDut1("midreset", '0, 1'b0, 1'b0, 1'b0);
    checkOutput("midreset busy", 16'(bus1.busy), 16'(0));
    applyStimulus(10'h34A, 1'b0);
    idle1();
    checkDut1("post reset", 10'h34A, 1'b1, 1'b0, 1'b0);
    ackPulse1();

    // Start bit ignored while disabled.
    en1 = 1'b0;
    @(negedge clk);
    ser1 = 1'b0;
    @(negedge clk);
    ser1 = 1'b1;
    checkOutput("disabled busy", 16'(bus1.busy), 16'(0));
    repeat (12) @(negedge clk);
    checkOutput("disabled valid", 16'(bus1.data_valid), 16'(0));

    // Dropping the enable mid-frame does not abort it.
    en1 = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      ser1 = vecs[2].frame[i];
      en1  = (i < 3);
    end
    idle1();
    checkDut1("en drop", 10'h3FE, 1'b1, 1'b0, 1'b0);
    en1 = 1'b1;
    ackPulse1();

    // 4 clocks per bit: a one-cycle glitch is rejected.
    @(negedge clk);
    ser4 = 1'b0;
    @(negedge clk);
    ser4 = 1'b1;
    checkOutput("glitch busy", 16'(bus4.busy), 16'(1));
    repeat (3) @(negedge clk);
    checkOutput("glitch busy end", 16'(bus4.busy), 16'(0));
    checkOutput("glitch valid", 16'(bus4.data_valid), 16'(0));

    // 4 clocks per bit: full frames.
    applyStimulus4(10'h34A);
    @(negedge clk);
    ser4 = 1'b1;
    checkOutput("slow data", 16'(bus4.data_out), 16'(10'h34A));
    checkOutput("slow valid", 16'(bus4.data_valid), 16'(1));
    checkOutput("slow err", 16'(bus4.frame_err), 16'(0));
    ack4 = 1'b1;
    @(negedge clk);
    ack4 = 1'b0;
    checkOutput("slow ack", 16'(bus4.data_valid), 16'(0));
    applyStimulus4(10'h14A);
    @(negedge clk);
    ser4 = 1'b1;
    checkOutput("slow err data", 16'(bus4.data_out), 16'(10'h14A));
    checkOutput("slow err flag", 16'(bus4.frame_err), 16'(1));

    // Random frames on the fast receiver from a clean reset.
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    runRandom();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
